instruction_fetch: RTL and testbench

Instruction fetch unit: the producer side of the decoder's instruction input. Keeps the program counter, issues word reads to instruction memory over a valid/ready request channel, and accepts in-order responses into a small FIFO. It presents instruction/PC pairs to the decode stage with a valid/ready handshake. Branch/jump redirects from the execute stage flush everything buffered and discard responses already in flight.

---
 rtl/instruction_fetch_if.sv | 28 ++
 rtl/instruction_fetch.sv | 120 ++++++++++++
 tb/tb_instruction_fetch.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/instruction_fetch_if.sv
// Fetch-unit bus: instruction memory request/response, execute redirect,
// and the instruction handoff to decode.
interface instruction_fetch_if;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] instruction;
  logic [31:0] pc_value;
  logic        fetch_fault;

  modport master (
    output imem_req_valid, imem_req_addr, inst_valid, instruction, pc_value, fetch_fault,
    input  imem_req_ready, imem_resp_valid, imem_resp_data, redirect_valid, redirect_pc,
           inst_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, inst_valid, instruction, pc_value, fetch_fault,
    output imem_req_ready, imem_resp_valid, imem_resp_data, redirect_valid, redirect_pc,
           inst_ready
  );
endinterface

// File: rtl/instruction_fetch.sv
// Instruction fetch unit: PC generation, credit-limited word fetches,
// in-order response buffering and redirect flush with in-flight discard.
//
// state | meaning
// RUN   | fetching normally, requests issued while credit remains
// FAULT | misaligned redirect seen; no requests until an aligned redirect
module instruction_fetch #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic clk,
  input  logic rst,
  instruction_fetch_if.master bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic {RUN = 1'b0, FAULT = 1'b1} mode_t;

  mode_t          mode_q, mode_d;
  logic [31:0]    pc_q;
  logic [CW-1:0]  fifo_cnt, keep_cnt, drop_cnt;
  logic [CW-1:0]  fifo_cnt_d, keep_cnt_d, drop_cnt_d;
  logic [PW-1:0]  rd_ptr, wr_ptr, pq_rd, pq_wr;
  logic [31:0]    fifo_pc    [DEPTH];
  logic [31:0]    fifo_instr [DEPTH];
  logic [31:0]    pq_mem     [DEPTH];

  logic [CW+1:0]  credit_used;
  logic           req_fire, resp, keep_resp, drop_resp, pop, push, redirect, aligned;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign credit_used = {2'b00, fifo_cnt} + {2'b00, keep_cnt} + {2'b00, drop_cnt};
  assign redirect    = bus.redirect_valid;
  assign aligned     = (bus.redirect_pc[1:0] == 2'b00);
  assign resp        = bus.imem_resp_valid;
  assign drop_resp   = resp && (drop_cnt != '0);
  assign keep_resp   = resp && (drop_cnt == '0);
  assign push        = keep_resp && !redirect;
  assign pop         = bus.inst_valid && bus.inst_ready;
  assign req_fire    = bus.imem_req_valid && bus.imem_req_ready;

  // Reset gates the request so nothing is issued while the unit is held.
  assign bus.imem_req_valid = rst && (mode_q == RUN) && (credit_used < (CW+2)'(DEPTH));
  assign bus.imem_req_addr  = pc_q;
  assign bus.inst_valid     = (fifo_cnt != '0);
  assign bus.instruction    = bus.inst_valid ? fifo_instr[rd_ptr] : 32'h0;
  assign bus.pc_value       = bus.inst_valid ? fifo_pc[rd_ptr]    : 32'h0;
  assign bus.fetch_fault    = (mode_q == FAULT);

  // Mode register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) mode_q <= RUN;
    else      mode_q <= mode_d;
  end

  // Mode transitions: any redirect decides RUN vs FAULT from target alignment.
  always_comb begin
    mode_d = mode_q;
    if (redirect) mode_d = aligned ? RUN : FAULT;
  end

  // Occupancy accounting; on redirect everything in flight becomes droppable,
  // including a response landing this cycle that would otherwise be kept.
  always_comb begin
    fifo_cnt_d = fifo_cnt + CW'(push) - CW'(pop);
    keep_cnt_d = keep_cnt + CW'(req_fire) - CW'(keep_resp);
    drop_cnt_d = drop_cnt - CW'(drop_resp);
    if (redirect) begin
      fifo_cnt_d = '0;
      keep_cnt_d = '0;
      drop_cnt_d = drop_cnt + keep_cnt + CW'(req_fire) - CW'(resp);
    end
  end

  // PC, counters and pointers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q     <= RESET_PC;
      fifo_cnt <= '0;
      keep_cnt <= '0;
      drop_cnt <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      pq_rd    <= '0;
      pq_wr    <= '0;
    end else begin
      fifo_cnt <= fifo_cnt_d;
      keep_cnt <= keep_cnt_d;
      drop_cnt <= drop_cnt_d;
      if (redirect)      pc_q <= bus.redirect_pc;
      else if (req_fire) pc_q <= pc_q + 32'd4;
      if (redirect) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push) wr_ptr <= nxt(wr_ptr);
        if (pop)  rd_ptr <= nxt(rd_ptr);
      end
      // The request-PC queue tracks every outstanding request, kept or dropped,
      // so it stays aligned with the in-order response stream across redirects.
      if (req_fire) pq_wr <= nxt(pq_wr);
      if (resp)     pq_rd <= nxt(pq_rd);
    end
  end

  // Storage arrays; contents are only observed through valid pointers/counts.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc[wr_ptr]    <= pq_mem[pq_rd];
      fifo_instr[wr_ptr] <= bus.imem_resp_data;
    end
    if (req_fire) pq_mem[pq_wr] <= pc_q;
  end

endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;
  localparam int          DEPTH  = 4;
  localparam logic [31:0] RST_PC = 32'hFFFF_FFF8;
  localparam logic [31:0] KEY    = 32'hA5A5_0000;

  logic clk = 1'b0;
  logic rst;

  instruction_fetch_if bus();

  instruction_fetch #(.DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int pops     = 0;
  logic [31:0] exp_q[$];
  bit faulted  = 1'b0;
  bit coincide = 1'b0;

  int ready_pct = 100;
  int inst_pct  = 100;
  int lat_min   = 1;
  int lat_max   = 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Expected delivery stream from a start address: consecutive words, wrapping mod 2^32.
  task automatic set_path(input logic [31:0] start);
    exp_q.delete();
    for (int i = 0; i < 400; i++) exp_q.push_back(start + 32'(i * 4));
  endtask

  // Instruction memory: in-order, latency lat_min..lat_max, data = addr ^ KEY.
  typedef struct { int due; logic [31:0] addr; } mreq_t;
  mreq_t pend[$];
  int cyc = 0;
  int last_due = 0;
  int m_due;
  initial begin
    bus.imem_req_ready  = 1'b0;
    bus.imem_resp_valid = 1'b0;
    bus.imem_resp_data  = 32'h0;
    bus.inst_ready      = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (!rst) begin
        pend.delete();
        last_due = 0;
        bus.imem_resp_valid = 1'b0;
      end else if (pend.size() > 0 && pend[0].due == cyc) begin
        bus.imem_resp_valid = 1'b1;
        bus.imem_resp_data  = pend[0].addr ^ KEY;
        void'(pend.pop_front());
      end else begin
        bus.imem_resp_valid = 1'b0;
        bus.imem_resp_data  = $urandom;
      end
      bus.imem_req_ready = ($urandom_range(0, 99) < ready_pct);
      bus.inst_ready     = ($urandom_range(0, 99) < inst_pct);
      @(negedge clk);
      if (rst && bus.imem_req_valid && bus.imem_req_ready) begin
        m_due = cyc + $urandom_range(lat_min, lat_max);
        if (m_due <= last_due) m_due = last_due + 1;
        last_due = m_due;
        pend.push_back('{m_due, bus.imem_req_addr});
      end
    end
  end

  // Monitor: compares every decode transfer against the expected stream.
  logic        prev_stall = 1'b0;
  logic        prev_redir = 1'b0;
  logic [31:0] prev_ins, prev_pc, mon_e;
  always @(negedge clk) begin
    if (!rst) begin
      prev_stall = 1'b0;
    end else begin
      if (!bus.inst_valid) begin
        check("empty_instr", bus.instruction, 32'h0);
        check("empty_pc", bus.pc_value, 32'h0);
      end
      if (prev_stall && !prev_redir) begin
        check("hold_valid", 32'(bus.inst_valid), 32'd1);
        check("hold_instr", bus.instruction, prev_ins);
        check("hold_pc", bus.pc_value, prev_pc);
      end
      if (bus.fetch_fault) check("fault_no_req", 32'(bus.imem_req_valid), 32'd0);
      if (bus.inst_valid && bus.inst_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_pop: got pc %h, no delivery expected", bus.pc_value);
        end else begin
          mon_e = exp_q.pop_front();
          check("pop_pc", bus.pc_value, mon_e);
          check("pop_instr", bus.instruction, mon_e ^ KEY);
        end
        pops++;
      end
      prev_stall = bus.inst_valid && !bus.inst_ready;
      prev_redir = bus.redirect_valid;
      prev_ins   = bus.instruction;
      prev_pc    = bus.pc_value;
    end
  end

  task automatic do_reset();
    @(posedge clk);
    #3;
    rst = 1'b0;
    exp_q.delete();
    faulted = 1'b0;
    #1;
    check("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
    check("rst_inst_valid", 32'(bus.inst_valid), 32'd0);
    check("rst_instr", bus.instruction, 32'h0);
    check("rst_pc_value", bus.pc_value, 32'h0);
    check("rst_fault", 32'(bus.fetch_fault), 32'd0);
    repeat (2) @(posedge clk);
    #2;
    set_path(RST_PC);
    rst = 1'b1;
    @(negedge clk);
    check("first_req_valid", 32'(bus.imem_req_valid), 32'd1);
    check("first_req_addr", bus.imem_req_addr, RST_PC);
  endtask

  task automatic do_redirect(input logic [31:0] tgt);
    @(posedge clk);
    #1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = tgt;
    @(negedge clk);
    coincide = bus.imem_req_valid && bus.imem_req_ready && bus.imem_resp_valid;
    @(posedge clk);
    #1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = $urandom;
    faulted = (tgt[1:0] != 2'b00);
    if (faulted) exp_q.delete();
    else         set_path(tgt);
    @(negedge clk);
    check("redir_inst_valid", 32'(bus.inst_valid), 32'd0);
    check("redir_fault", 32'(bus.fetch_fault), 32'(faulted));
  endtask

  int nreq;
  int p0;
  logic [31:0] tgt;
  initial begin
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    rst = 1'b1;
    #1 rst = 1'b0;

    // Back-to-back streaming from reset, across the address wrap.
    ready_pct = 100; inst_pct = 100; lat_min = 1; lat_max = 1;
    do_reset();
    for (int c = 2; c <= 22; c++) begin
      @(negedge clk);
      check("tput_valid", 32'(bus.inst_valid), 32'(c >= 3));
      check("tput_req", 32'(bus.imem_req_valid), 32'd1);
    end

    // Decode stalled: exactly DEPTH new-path requests, then the fetch stops.
    inst_pct = 0;
    do_redirect(32'h0000_0400);
    nreq = 0;
    for (int i = 0; i < 12; i++) begin
      if (i > 0) @(negedge clk);
      if (bus.imem_req_valid && bus.imem_req_ready) begin
        check("bp_addr", bus.imem_req_addr, 32'h0000_0400 + 32'(nreq * 4));
        nreq++;
      end
    end
    check("bp_count", 32'(nreq), 32'(DEPTH));
    check("bp_req_idle", 32'(bus.imem_req_valid), 32'd0);
    check("bp_inst_valid", 32'(bus.inst_valid), 32'd1);
    check("bp_head_pc", bus.pc_value, 32'h0000_0400);
    inst_pct = 100;
    p0 = pops;
    for (int i = 0; i < 30 && pops < p0 + 4; i++) @(negedge clk);
    check("bp_drain", 32'(pops >= p0 + 4), 32'd1);

    // Redirect coinciding with a response and a request acceptance.
    repeat (6) @(negedge clk);
    do_redirect(32'h0000_0800);
    check("redir_coincide", 32'(coincide), 32'd1);
    p0 = pops;
    repeat (12) @(negedge clk);
    check("coincide_resume", 32'(pops > p0), 32'd1);

    // Fixed latency 3 with requests in flight at the redirect.
    lat_min = 3; lat_max = 3;
    repeat (10) @(negedge clk);
    do_redirect(32'h0000_0100);
    p0 = pops;
    repeat (15) @(negedge clk);
    check("l3_resume", 32'(pops > p0), 32'd1);

    // Misaligned redirect halts fetch until an aligned redirect.
    lat_min = 1;
    do_redirect(32'h0000_0102);
    check("fault_req_valid", 32'(bus.imem_req_valid), 32'd0);
    repeat (8) @(negedge clk);
    check("fault_held", 32'(bus.fetch_fault), 32'd1);
    check("fault_req_idle", 32'(bus.imem_req_valid), 32'd0);
    check("fault_inst_idle", 32'(bus.inst_valid), 32'd0);
    do_redirect(32'h0000_0200);
    check("unfault_req_valid", 32'(bus.imem_req_valid), 32'd1);
    check("unfault_req_addr", bus.imem_req_addr, 32'h0000_0200);
    repeat (10) @(negedge clk);

    // Randomized traffic with redirects, faults and asynchronous resets.
    for (int it = 0; it < 40; it++) begin
      ready_pct = $urandom_range(30, 100);
      inst_pct  = $urandom_range(20, 100);
      lat_min   = 1;
      lat_max   = $urandom_range(1, 3);
      repeat ($urandom_range(5, 40)) @(negedge clk);
      case ($urandom_range(0, 9))
        0: do_reset();
        1: begin
          tgt = ($urandom & 32'hFFFF_FFFC) | 32'($urandom_range(1, 3));
          do_redirect(tgt);
        end
        default: begin
          tgt = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 : ($urandom & 32'hFFFF_FFFC);
          do_redirect(tgt);
        end
      endcase
    end
    repeat (10) @(negedge clk);
    check("total_pops", 32'(pops > 100), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
